// File: rtl/perf_monitor.sv
`default_nettype none
// ============================================================================
// Module   : perf_monitor
// Purpose  : Run/performance monitor placed beside a core. Counts cycles,
//            retired instructions and generic events while a measurement is
//            running, detects completion when DONE_REG is written with
//            DONE_VALUE, enforces a cycle watchdog and freezes a report once
//            a settle window after completion has elapsed.
// Ports    : clk, rst            - clock, asynchronous active-high reset
//            start               - begin a measurement (IDLE/REPORT/TIMEOUT)
//            commit_cnt          - instructions retired this cycle
//            wb_valid/rd/data    - per-lane architectural writebacks
//            event_i             - one-cycle event strobes
//            busy                - RUN or SETTLE
//            done, timeout       - sticky completion / watchdog flags
//            report_valid        - counters frozen and final
//            cycle_count, instr_count, event_count - saturating counters
// Revision : 1.0 - initial release
// ============================================================================
module perf_monitor #(
  parameter int              XLEN          = 32,
  parameter int              COMMIT_WIDTH  = 2,
  parameter int              NUM_WB        = 2,
  parameter int              NUM_EVENTS    = 4,
  parameter int              CNT_W         = 32,
  parameter int              DONE_REG      = 31,
  parameter logic [XLEN-1:0] DONE_VALUE    = 'hFF,
  parameter int              MAX_CYCLES    = 300,
  parameter int              SETTLE_CYCLES = 10
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [$clog2(COMMIT_WIDTH+1)-1:0]    commit_cnt,
  input  logic [NUM_WB-1:0]                    wb_valid,
  input  logic [NUM_WB*5-1:0]                  wb_rd,
  input  logic [NUM_WB*XLEN-1:0]               wb_data,
  input  logic [NUM_EVENTS-1:0]                event_i,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 timeout,
  output logic                                 report_valid,
  output logic [CNT_W-1:0]                     cycle_count,
  output logic [CNT_W-1:0]                     instr_count,
  output logic [NUM_EVENTS*CNT_W-1:0]          event_count
);

  // Settle counter only has to hold 0 .. SETTLE_CYCLES-1.
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0] SETTLE_LAST =
    SET_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  // Watchdog compare is done 32 bits wider than the counter so a narrow
  // counter simply never matches instead of aliasing onto a truncated limit.
  localparam logic [CNT_W+31:0] WD_LAST = (CNT_W+32)'(MAX_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_SETTLE  = 3'd2,
    S_REPORT  = 3'd3,
    S_TIMEOUT = 3'd4
  } state_t;

  state_t            state_q;
  logic [SET_W-1:0]  settle_q;
  logic              busy_q, done_q, timeout_q, report_valid_q;
  logic [CNT_W-1:0]  cycle_q, instr_q;
  logic [CNT_W-1:0]  ev_q [NUM_EVENTS];

  logic [CNT_W-1:0]  cycle_d, instr_d;
  logic [CNT_W-1:0]  ev_d [NUM_EVENTS];
  logic              w_hit, w_wd;

  // Saturation is judged on the carry-out of the full-width sum, so any
  // increment that would pass all-ones clamps there.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  always_comb begin
    cycle_d = sat_add(cycle_q, CNT_W'(1));
    instr_d = sat_add(instr_q, CNT_W'(commit_cnt));
    for (int k = 0; k < NUM_EVENTS; k++) begin
      ev_d[k] = sat_add(ev_q[k], CNT_W'(event_i[k]));
    end
    // Any number of simultaneous lane hits collapses to a single hit.
    w_hit = 1'b0;
    for (int k = 0; k < NUM_WB; k++) begin
      if (wb_valid[k] && (wb_rd[5*k +: 5] == 5'(DONE_REG)) &&
          (wb_data[XLEN*k +: XLEN] == DONE_VALUE)) begin
        w_hit = 1'b1;
      end
    end
    w_wd = ({32'd0, cycle_q} == WD_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      settle_q       <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      timeout_q      <= 1'b0;
      report_valid_q <= 1'b0;
      cycle_q        <= '0;
      instr_q        <= '0;
      for (int k = 0; k < NUM_EVENTS; k++) ev_q[k] <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_REPORT, S_TIMEOUT: begin
          if (start) begin
            state_q        <= S_RUN;
            busy_q         <= 1'b1;
            done_q         <= 1'b0;
            timeout_q      <= 1'b0;
            report_valid_q <= 1'b0;
            cycle_q        <= '0;
            instr_q        <= '0;
            for (int k = 0; k < NUM_EVENTS; k++) ev_q[k] <= '0;
          end
        end
        S_RUN: begin
          cycle_q <= cycle_d;
          instr_q <= instr_d;
          for (int k = 0; k < NUM_EVENTS; k++) ev_q[k] <= ev_d[k];
          // A hit takes priority over a watchdog expiry in the same cycle.
          if (w_hit) begin
            done_q   <= 1'b1;
            settle_q <= '0;
            if (SETTLE_CYCLES == 0) begin
              state_q        <= S_REPORT;
              busy_q         <= 1'b0;
              report_valid_q <= 1'b1;
            end else begin
              state_q <= S_SETTLE;
            end
          end else if (w_wd) begin
            state_q        <= S_TIMEOUT;
            timeout_q      <= 1'b1;
            busy_q         <= 1'b0;
            report_valid_q <= 1'b1;
          end
        end
        S_SETTLE: begin
          cycle_q <= cycle_d;
          instr_q <= instr_d;
          for (int k = 0; k < NUM_EVENTS; k++) ev_q[k] <= ev_d[k];
          if (settle_q == SETTLE_LAST) begin
            state_q        <= S_REPORT;
            busy_q         <= 1'b0;
            report_valid_q <= 1'b1;
          end else begin
            settle_q <= settle_q + SET_W'(1);
          end
        end
        default: begin
          state_q        <= S_IDLE;
          busy_q         <= 1'b0;
          report_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign timeout      = timeout_q;
  assign report_valid = report_valid_q;
  assign cycle_count  = cycle_q;
  assign instr_count  = instr_q;

  for (genvar k = 0; k < NUM_EVENTS; k++) begin : g_evout
    assign event_count[k*CNT_W +: CNT_W] = ev_q[k];
  end

endmodule
`default_nettype wire

// File: doc/perf_monitor.md
Name: perf_monitor

Overview:
- Synthesizable run/performance monitor, instantiated alongside the core to watch commit and writeback traffic.
- Counts cycles, retired instructions and NUM_EVENTS generic microarchitectural events (flushes, stalls, mispredicts).
- Detects program completion when an architectural register is written with a sentinel value; enforces a cycle watchdog; freezes a report after a settle window.
- Multi-lane, parametrised in commit width, writeback ports and event count; usable in simulation and on FPGA.

Parameters:
- XLEN, 32, writeback data width.
- COMMIT_WIDTH, 2, max instructions retired per cycle.
- NUM_WB, 2, writeback lanes watched for completion.
- NUM_EVENTS, 4, generic event inputs counted.
- CNT_W, 32, width of every counter.
- DONE_REG, 31, architectural register watched; must be 1..31.
- DONE_VALUE, 32'h000000FF, sentinel value signalling completion.
- MAX_CYCLES, 300, watchdog limit in RUN cycles.
- SETTLE_CYCLES, 10, cycles counted after completion before freezing.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a measurement; honoured in IDLE, REPORT and TIMEOUT only.
- commit_cnt  in  $clog2(COMMIT_WIDTH+1)  instructions retired this cycle.
- wb_valid  in  NUM_WB  per-lane architectural writeback valid.
- wb_rd  in  NUM_WB*5  per-lane destination register, lane k at [5k+:5].
- wb_data  in  NUM_WB*XLEN  per-lane write data.
- event_i  in  NUM_EVENTS  one-cycle event strobes.
- busy  out  1  state is RUN or SETTLE.
- done  out  1  completion detected; sticky until next start or reset.
- timeout  out  1  watchdog expired; sticky until next start or reset.
- report_valid  out  1  counters frozen and final.
- cycle_count  out  CNT_W  cycles counted.
- instr_count  out  CNT_W  instructions retired.
- event_count  out  NUM_EVENTS*CNT_W  per-event totals, event k at [k*CNT_W+:CNT_W].

Behaviour:
- States: IDLE, RUN, SETTLE, REPORT, TIMEOUT.
- Reset (asynchronous, takes effect immediately at any point, including mid-run):
  - State goes to IDLE.
  - All counters, done, timeout, report_valid and busy are 0.
  - The settle counter is cleared.
- IDLE:
  - Counters hold.
  - start=1 clears all counters, done and timeout, and moves to RUN on the next edge.
  - The start cycle itself is not counted.
- RUN, every cycle:
  - cycle_count += 1.
  - instr_count += commit_cnt.
  - event_count[k] += event_i[k].
  - All counters saturate at all-ones; there is no wrap.
- Completion hit:
  - A hit occurs when any lane k has wb_valid[k], wb_rd[k]==DONE_REG and wb_data[k]==DONE_VALUE.
  - Multiple lanes hitting together count as one hit.
  - On a hit in RUN: the hit cycle is still counted, done is set, the settle counter is loaded with 0, and the next state is SETTLE.
- Watchdog:
  - In RUN, with no hit this cycle, and cycle_count==MAX_CYCLES-1 before the increment: count this cycle, set timeout, and go to TIMEOUT.
  - Hit and watchdog in the same cycle: done wins and timeout stays 0.
- SETTLE:
  - Counters keep accumulating exactly as in RUN.
  - Further hits are ignored and the watchdog is disabled.
  - After SETTLE_CYCLES cycles in SETTLE, go to REPORT.
  - SETTLE_CYCLES=0 means the hit cycle goes directly to REPORT.
- REPORT and TIMEOUT:
  - Counters frozen and report_valid=1.
  - start restarts exactly as from IDLE: counters cleared and report_valid dropped on the next edge.
- busy is 1 in RUN and SETTLE only.
- start asserted during RUN or SETTLE is ignored.
- Inputs are ignored in IDLE, REPORT and TIMEOUT.
- All outputs are registered: a value reflects state after the edge, with no combinational path from inputs to outputs.
- Increment widths: the commit_cnt addition is zero-extended to CNT_W. Saturation is checked on the full-width sum, so a +2 add at all-ones-minus-1 clamps to all-ones.

Test Plan:
- Basic run: reset, start. Drive commit_cnt=1 for 20 cycles, then lane 0 writes rd=31, data=0xFF on cycle 21 with commit_cnt=1, then commit_cnt=1 through settle. Required: done=1; REPORT after 10 settle cycles; cycle_count=31, instr_count=31; report_valid=1; timeout=0.
- Watchdog: start, commit_cnt=2 every cycle, no hit. Required: TIMEOUT after 300 counted cycles; cycle_count=300, instr_count=600; timeout=1, done=0; counters frozen afterwards.
- Same-cycle boundary: hit exactly on the 300th RUN cycle. Required: done=1, timeout=0, enters SETTLE, final cycle_count=310.
- Near-miss and multi-lane: a write of rd=31 with data=0xFE, or rd=30 with data=0xFF, does not complete. Lane 1 plus lane 0 hitting together set done once, with no double transition.
- Events and saturation: event_i[2] pulses 5 times → event_count[2]=5, others 0. With CNT_W=4, commit_cnt=2 for 10 cycles → instr_count=15 (saturated).
- Reset and restart: assert rst mid-SETTLE → all outputs 0 immediately, state IDLE. start in REPORT → counters clear and report_valid=0 on the next edge. start pulsed during RUN has no effect on counts.
